// File: rtl/e203_exu_disp_sb.sv
// EXU dispatch stage with an integrated in-order outstanding-instruction scoreboard.
// Optional precise WAW check: define E203_DISP_PRECISE_WAW_EN.
module e203_exu_disp_sb #(
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter int INFO_W     = 21,
  parameter int OITF_DEPTH = 2,
  parameter int ITAG_W     = 1,
  parameter int FENCE_BIT  = 19,
  parameter int FENCEI_BIT = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wfi_halt_exu_req,
  output logic               wfi_halt_exu_ack,
  input  logic               amo_wait,
  input  logic               disp_i_valid,
  output logic               disp_i_ready,
  input  logic               disp_i_rs1x0,
  input  logic               disp_i_rs2x0,
  input  logic               disp_i_rs1en,
  input  logic               disp_i_rs2en,
  input  logic               disp_i_rdwen,
  input  logic [RFIDX_W-1:0] disp_i_rs1idx,
  input  logic [RFIDX_W-1:0] disp_i_rs2idx,
  input  logic [RFIDX_W-1:0] disp_i_rdidx,
  input  logic [XLEN-1:0]    disp_i_rs1,
  input  logic [XLEN-1:0]    disp_i_rs2,
  input  logic [XLEN-1:0]    disp_i_imm,
  input  logic [XLEN-1:0]    disp_i_pc,
  input  logic [INFO_W-1:0]  disp_i_info,
  input  logic               disp_i_misalgn,
  input  logic               disp_i_buserr,
  input  logic               disp_i_ilegl,
  output logic               disp_o_alu_valid,
  input  logic               disp_o_alu_ready,
  input  logic               disp_o_alu_longpipe,
  output logic [XLEN-1:0]    disp_o_alu_rs1,
  output logic [XLEN-1:0]    disp_o_alu_rs2,
  output logic [XLEN-1:0]    disp_o_alu_imm,
  output logic [XLEN-1:0]    disp_o_alu_pc,
  output logic               disp_o_alu_rdwen,
  output logic [RFIDX_W-1:0] disp_o_alu_rdidx,
  output logic [INFO_W-1:0]  disp_o_alu_info,
  output logic               disp_o_alu_misalgn,
  output logic               disp_o_alu_buserr,
  output logic               disp_o_alu_ilegl,
  output logic [ITAG_W-1:0]  disp_o_alu_itag,
  input  logic               oitf_ret_ena,
  output logic [ITAG_W-1:0]  oitf_ret_ptr,
  output logic               oitf_ret_rdwen,
  output logic [RFIDX_W-1:0] oitf_ret_rdidx,
  output logic [XLEN-1:0]    oitf_ret_pc,
  output logic               oitf_empty,
  output logic               oitf_full
);

  localparam logic [ITAG_W-1:0] LAST_PTR = ITAG_W'(OITF_DEPTH - 1);

  logic [OITF_DEPTH-1:0] vld;
  logic [OITF_DEPTH-1:0] e_rdwen;
  logic [RFIDX_W-1:0]    e_rdidx [OITF_DEPTH];
  logic [XLEN-1:0]       e_pc    [OITF_DEPTH];
  logic [ITAG_W-1:0]     wptr;
  logic [ITAG_W-1:0]     rptr;
  logic                  wflag;
  logic                  rflag;

  logic       raw_dep;
  logic       waw_dep;
  logic [2:0] grp;
  logic       is_csr;
  logic       is_fence;
  logic       longp_prdt;
  logic       disp_cond;
  logic       alloc_fire;
  logic       ret_fire;

  // Returns {flag, ptr} advanced by one, toggling the flag on wrap.
  function automatic logic [ITAG_W:0] ptr_adv(input logic flag, input logic [ITAG_W-1:0] ptr);
    if (ptr == LAST_PTR) return {~flag, {ITAG_W{1'b0}}};
    return {flag, ptr + ITAG_W'(1)};
  endfunction

  assign oitf_empty = (wptr == rptr) & (wflag == rflag);
  assign oitf_full  = (wptr == rptr) & (wflag != rflag);

  always_comb begin
    raw_dep = 1'b0;
    waw_dep = 1'b0;
    for (int i = 0; i < OITF_DEPTH; i++) begin
      if (vld[i] & e_rdwen[i]) begin
        if (disp_i_rs1en & ~disp_i_rs1x0 & (disp_i_rs1idx == e_rdidx[i])) raw_dep = 1'b1;
        if (disp_i_rs2en & ~disp_i_rs2x0 & (disp_i_rs2idx == e_rdidx[i])) raw_dep = 1'b1;
`ifdef E203_DISP_PRECISE_WAW_EN
        if (disp_i_rdwen & (disp_i_rdidx == e_rdidx[i])) waw_dep = 1'b1;
`else
        if (disp_i_rdidx == e_rdidx[i]) waw_dep = 1'b1;
`endif
      end
    end
  end

  assign grp        = disp_i_info[2:0];
  assign is_csr     = (grp == 3'd3);
  assign is_fence   = (grp == 3'd2) & (disp_i_info[FENCE_BIT] | disp_i_info[FENCEI_BIT]);
  assign longp_prdt = (grp == 3'd1);

  assign disp_cond = ~raw_dep & ~waw_dep & ~wfi_halt_exu_req
                   & ((is_csr | is_fence) ? oitf_empty : 1'b1)
                   & (longp_prdt ? ~oitf_full : 1'b1);

  assign disp_o_alu_valid = disp_i_valid & disp_cond;
  assign disp_i_ready     = disp_cond & disp_o_alu_ready;

  assign alloc_fire = disp_o_alu_valid & disp_o_alu_ready & disp_o_alu_longpipe;
  assign ret_fire   = oitf_ret_ena & ~oitf_empty;

  assign disp_o_alu_rs1     = disp_i_rs1x0 ? '0 : disp_i_rs1;
  assign disp_o_alu_rs2     = disp_i_rs2x0 ? '0 : disp_i_rs2;
  assign disp_o_alu_imm     = disp_i_imm;
  assign disp_o_alu_pc      = disp_i_pc;
  assign disp_o_alu_rdwen   = disp_i_rdwen;
  assign disp_o_alu_rdidx   = disp_i_rdidx;
  assign disp_o_alu_info    = disp_i_info;
  assign disp_o_alu_misalgn = disp_i_misalgn;
  assign disp_o_alu_buserr  = disp_i_buserr;
  assign disp_o_alu_ilegl   = disp_i_ilegl;
  assign disp_o_alu_itag    = wptr;

  assign oitf_ret_ptr   = rptr;
  assign oitf_ret_rdwen = e_rdwen[rptr];
  assign oitf_ret_rdidx = e_rdidx[rptr];
  assign oitf_ret_pc    = e_pc[rptr];

  assign wfi_halt_exu_ack = oitf_empty & ~amo_wait;

  // Scoreboard control state; allocation is applied after retire so it wins on a shared slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      wflag <= 1'b0;
      rflag <= 1'b0;
    end else begin
      if (ret_fire) begin
        vld[rptr]     <= 1'b0;
        {rflag, rptr} <= ptr_adv(rflag, rptr);
      end
      if (alloc_fire) begin
        vld[wptr]     <= 1'b1;
        {wflag, wptr} <= ptr_adv(wflag, wptr);
      end
    end
  end

  // Entry payload, written on allocation only.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      e_rdwen[wptr] <= disp_i_rdwen;
      e_rdidx[wptr] <= disp_i_rdidx;
      e_pc[wptr]    <= disp_i_pc;
    end
  end

endmodule

// File: tb/tb_e203_exu_disp_sb.sv
// Directed self-checking bench for e203_exu_disp_sb (default OITF_DEPTH=2).
module tb_e203_exu_disp_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic        wfi_halt_exu_req, wfi_halt_exu_ack, amo_wait;
  logic        disp_i_valid, disp_i_ready;
  logic        disp_i_rs1x0, disp_i_rs2x0, disp_i_rs1en, disp_i_rs2en, disp_i_rdwen;
  logic [4:0]  disp_i_rs1idx, disp_i_rs2idx, disp_i_rdidx;
  logic [31:0] disp_i_rs1, disp_i_rs2, disp_i_imm, disp_i_pc;
  logic [20:0] disp_i_info;
  logic        disp_i_misalgn, disp_i_buserr, disp_i_ilegl;
  logic        disp_o_alu_valid, disp_o_alu_ready, disp_o_alu_longpipe;
  logic [31:0] disp_o_alu_rs1, disp_o_alu_rs2, disp_o_alu_imm, disp_o_alu_pc;
  logic        disp_o_alu_rdwen;
  logic [4:0]  disp_o_alu_rdidx;
  logic [20:0] disp_o_alu_info;
  logic        disp_o_alu_misalgn, disp_o_alu_buserr, disp_o_alu_ilegl;
  logic [0:0]  disp_o_alu_itag;
  logic        oitf_ret_ena;
  logic [0:0]  oitf_ret_ptr;
  logic        oitf_ret_rdwen;
  logic [4:0]  oitf_ret_rdidx;
  logic [31:0] oitf_ret_pc;
  logic        oitf_empty, oitf_full;

  int npass = 0;
  int ntot  = 0;

  e203_exu_disp_sb dut (
    .clk(clk), .rst(rst),
    .wfi_halt_exu_req(wfi_halt_exu_req), .wfi_halt_exu_ack(wfi_halt_exu_ack), .amo_wait(amo_wait),
    .disp_i_valid(disp_i_valid), .disp_i_ready(disp_i_ready),
    .disp_i_rs1x0(disp_i_rs1x0), .disp_i_rs2x0(disp_i_rs2x0),
    .disp_i_rs1en(disp_i_rs1en), .disp_i_rs2en(disp_i_rs2en), .disp_i_rdwen(disp_i_rdwen),
    .disp_i_rs1idx(disp_i_rs1idx), .disp_i_rs2idx(disp_i_rs2idx), .disp_i_rdidx(disp_i_rdidx),
    .disp_i_rs1(disp_i_rs1), .disp_i_rs2(disp_i_rs2), .disp_i_imm(disp_i_imm), .disp_i_pc(disp_i_pc),
    .disp_i_info(disp_i_info),
    .disp_i_misalgn(disp_i_misalgn), .disp_i_buserr(disp_i_buserr), .disp_i_ilegl(disp_i_ilegl),
    .disp_o_alu_valid(disp_o_alu_valid), .disp_o_alu_ready(disp_o_alu_ready),
    .disp_o_alu_longpipe(disp_o_alu_longpipe),
    .disp_o_alu_rs1(disp_o_alu_rs1), .disp_o_alu_rs2(disp_o_alu_rs2),
    .disp_o_alu_imm(disp_o_alu_imm), .disp_o_alu_pc(disp_o_alu_pc),
    .disp_o_alu_rdwen(disp_o_alu_rdwen), .disp_o_alu_rdidx(disp_o_alu_rdidx),
    .disp_o_alu_info(disp_o_alu_info),
    .disp_o_alu_misalgn(disp_o_alu_misalgn), .disp_o_alu_buserr(disp_o_alu_buserr),
    .disp_o_alu_ilegl(disp_o_alu_ilegl), .disp_o_alu_itag(disp_o_alu_itag),
    .oitf_ret_ena(oitf_ret_ena), .oitf_ret_ptr(oitf_ret_ptr),
    .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdidx(oitf_ret_rdidx), .oitf_ret_pc(oitf_ret_pc),
    .oitf_empty(oitf_empty), .oitf_full(oitf_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wfi_halt_exu_req = 0; amo_wait = 0; disp_i_valid = 0;
    disp_i_rs1x0 = 0; disp_i_rs2x0 = 0; disp_i_rs1en = 0; disp_i_rs2en = 0; disp_i_rdwen = 0;
    disp_i_rs1idx = 0; disp_i_rs2idx = 0; disp_i_rdidx = 0;
    disp_i_rs1 = 0; disp_i_rs2 = 0; disp_i_imm = 0; disp_i_pc = 0; disp_i_info = 0;
    disp_i_misalgn = 0; disp_i_buserr = 0; disp_i_ilegl = 0;
    disp_o_alu_ready = 1; disp_o_alu_longpipe = 0; oitf_ret_ena = 0;
  endtask

  // Present a long-pipe (group 1) instruction writing rd.
  task automatic longp(input logic [4:0] rd, input logic [31:0] pc);
    clr();
    disp_i_valid = 1; disp_i_info = 21'd1; disp_i_rdwen = 1; disp_i_rdidx = rd;
    disp_i_pc = pc; disp_o_alu_longpipe = 1;
  endtask

  initial begin
    clr();
    rst = 1;
    step(); step();
    rst = 0;
    #1;
    check("rst_empty", oitf_empty, 1);
    check("rst_full", oitf_full, 0);
    check("rst_ack", wfi_halt_exu_ack, 1);

    // First long-pipe allocation of x5
    longp(5'd5, 32'h100);
    #1;
    check("alloc_ready", disp_i_ready, 1);
    check("alloc_valid", disp_o_alu_valid, 1);
    check("alloc_itag", disp_o_alu_itag, 0);
    step();
    clr();
    #1;
    check("x5_empty", oitf_empty, 0);
    check("x5_ret_rdidx", oitf_ret_rdidx, 5);
    check("x5_ret_pc", oitf_ret_pc, 32'h100);
    check("x5_ret_rdwen", oitf_ret_rdwen, 1);
    check("x5_ack", wfi_halt_exu_ack, 0);

    // RAW on x5, released one cycle after retire
    disp_i_valid = 1; disp_i_rs1en = 1; disp_i_rs1idx = 5;
    #1;
    check("raw_ready", disp_i_ready, 0);
    check("raw_valid", disp_o_alu_valid, 0);
    oitf_ret_ena = 1;
    #1;
    check("raw_no_bypass", disp_i_ready, 0);
    step();
    oitf_ret_ena = 0;
    #1;
    check("raw_release_ready", disp_i_ready, 1);
    check("raw_release_valid", disp_o_alu_valid, 1);
    check("raw_release_empty", oitf_empty, 1);
    step();

    // x0 source: zeroed operand and no RAW against an entry with rdidx 0
    longp(5'd0, 32'h200);
    #1;
    check("x0_alloc_itag", disp_o_alu_itag, 1);
    step();
    clr();
    disp_i_valid = 1; disp_i_rs1en = 1; disp_i_rs1x0 = 1; disp_i_rs1idx = 0;
    disp_i_rs1 = 32'hDEADBEEF; disp_i_rs2 = 32'h1234; disp_i_rdwen = 1; disp_i_rdidx = 3;
    disp_i_imm = 32'h55; disp_i_pc = 32'h204; disp_i_ilegl = 1;
    #1;
    check("x0_rs1_zero", disp_o_alu_rs1, 0);
    check("x0_rs2_pass", disp_o_alu_rs2, 32'h1234);
    check("x0_imm_pass", disp_o_alu_imm, 32'h55);
    check("x0_ilegl_pass", disp_o_alu_ilegl, 1);
    check("x0_no_raw", disp_i_ready, 1);
    step();
    clr();
    oitf_ret_ena = 1;
    step();
    oitf_ret_ena = 0;
    #1;
    check("x0_retired_empty", oitf_empty, 1);

    // Fill to full; wptr wraps to 0
    longp(5'd1, 32'h300);
    #1;
    check("fill1_itag", disp_o_alu_itag, 0);
    step();
    longp(5'd2, 32'h304);
    #1;
    check("fill2_itag", disp_o_alu_itag, 1);
    step();
    longp(5'd3, 32'h308);
    #1;
    check("full_flag", oitf_full, 1);
    check("full_wrap_itag", disp_o_alu_itag, 0);
    check("full_stall", disp_i_ready, 0);
    check("full_head_rdidx", oitf_ret_rdidx, 1);
    oitf_ret_ena = 1;
    #1;
    check("full_stall_on_ret", disp_i_ready, 0);
    step();
    #1;
    check("after_ret_full", oitf_full, 0);
    check("after_ret_ptr", oitf_ret_ptr, 1);
    check("simul_ready", disp_i_ready, 1);
    check("simul_itag", disp_o_alu_itag, 0);
    check("simul_head_rdidx", oitf_ret_rdidx, 2);
    step();
    clr();
    #1;
    check("simul_empty", oitf_empty, 0);
    check("simul_full", oitf_full, 0);
    check("simul_head_ptr", oitf_ret_ptr, 0);
    check("simul_head_x3", oitf_ret_rdidx, 3);
    check("simul_head_pc", oitf_ret_pc, 32'h308);

    // Fence and CSR wait for drain
    disp_i_valid = 1; disp_i_info = 21'd2 | (21'd1 << 19);
    #1;
    check("fence_stall", disp_i_ready, 0);
    disp_i_info = 21'd2 | (21'd1 << 20);
    #1;
    check("fencei_stall", disp_i_ready, 0);
    disp_i_info = 21'd2;
    #1;
    check("grp2_nofence_pass", disp_i_ready, 1);
    disp_i_info = 21'd3; disp_i_rdwen = 1; disp_i_rdidx = 9;
    #1;
    check("csr_stall", disp_i_ready, 0);
    check("csr_valid_low", disp_o_alu_valid, 0);
    oitf_ret_ena = 1;
    step();
    oitf_ret_ena = 0;
    #1;
    check("csr_accept", disp_i_ready, 1);
    check("csr_itag", disp_o_alu_itag, 1);
    step();

    // Store-like instruction against x7: WAW behaviour depends on the build
    longp(5'd7, 32'h400);
    step();
    clr();
    disp_i_valid = 1; disp_i_rdwen = 0; disp_i_rdidx = 7;
    #1;
`ifdef E203_DISP_PRECISE_WAW_EN
    check("store_waw", disp_i_ready, 1);
`else
    check("store_waw", disp_i_ready, 0);
`endif
    disp_i_rdwen = 1;
    #1;
    check("rd_waw", disp_i_ready, 0);

    // WFI halt and ack
    disp_i_rdwen = 0; disp_i_rdidx = 0; wfi_halt_exu_req = 1;
    #1;
    check("wfi_valid", disp_o_alu_valid, 0);
    check("wfi_ack_busy", wfi_halt_exu_ack, 0);
    oitf_ret_ena = 1;
    step();
    oitf_ret_ena = 0;
    #1;
    check("wfi_ack_empty", wfi_halt_exu_ack, 1);
    amo_wait = 1;
    #1;
    check("wfi_ack_amo", wfi_halt_exu_ack, 0);

    // Backpressure from the ALU
    clr();
    disp_i_valid = 1; disp_o_alu_ready = 0;
    #1;
    check("bp_valid", disp_o_alu_valid, 1);
    check("bp_ready", disp_i_ready, 0);

    // Retire while empty is ignored
    clr();
    oitf_ret_ena = 1;
    step();
    oitf_ret_ena = 0;
    #1;
    check("ret_empty_empty", oitf_empty, 1);
    check("ret_empty_full", oitf_full, 0);
    check("ret_empty_rptr", oitf_ret_ptr, 0);
    check("ret_empty_wptr", disp_o_alu_itag, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
